// File: rtl/uart_tx_sched.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_sched
// Purpose  : Round-robin scheduler sharing one 8N1 UART transmitter between
//            NUM_REQ byte producers. It accepts one byte per grant, fires the
//            transmitter strobe, then blocks all requesters for one frame
//            time, because the transmitter reports no busy status.
// Options  : UART_TX_SCHED_STATS_EN adds a 16-bit wrapping frame_count output
//            that counts transmitted frames.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_sched #(
    parameter int NUM_REQ    = 2,
    parameter int BIT_CYCLES = 105,
    parameter int FRAME_BITS = 11,
    parameter int GID_W      = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [7:0]           tx_data,
    output logic                 new_message,
    output logic                 busy,
    output logic [GID_W-1:0]     grant_id
`ifdef UART_TX_SCHED_STATS_EN
    ,
    output logic [15:0]          frame_count
`endif
);

    // One frame time in clk cycles; the hold-off counter runs F-1 down to 0.
    localparam int                c_frame_cycles = FRAME_BITS * BIT_CYCLES;
    localparam int                c_cnt_w        = (c_frame_cycles > 1) ? $clog2(c_frame_cycles) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_max     = c_cnt_w'(c_frame_cycles - 1);
    localparam logic [GID_W:0]    c_num_req      = (GID_W + 1)'(NUM_REQ);
    localparam logic [GID_W-1:0]  c_last_id      = GID_W'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STROBE = 2'd1,
        S_WAIT   = 2'd2
    } state_t;

    state_t               r_state;
    logic [c_cnt_w-1:0]   r_wait_cnt;
    logic [GID_W-1:0]     r_rr_ptr;
    logic [GID_W-1:0]     r_grant_id;
    logic [7:0]           r_tx_data;
    logic                 r_new_message;

    logic                 w_found;
    logic [GID_W-1:0]     w_winner;
    logic [GID_W:0]       w_idx;
    logic [GID_W-1:0]     w_next_ptr;
    logic [NUM_REQ-1:0]   w_ready;

    // Round-robin search: first valid requester starting at r_rr_ptr, wrapping.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_idx    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_idx = {1'b0, r_rr_ptr} + (GID_W + 1)'(k);
            if (w_idx >= c_num_req) begin
                w_idx = w_idx - c_num_req;
            end
            if (!w_found && req_valid[w_idx[GID_W-1:0]]) begin
                w_found  = 1'b1;
                w_winner = w_idx[GID_W-1:0];
            end
        end
    end

    // Pointer moves just past the winner so it gets lowest priority next time.
    assign w_next_ptr = (w_winner == c_last_id) ? '0 : w_winner + GID_W'(1);

    // Accept is only offered while idle; at most one bit is ever set.
    always_comb begin
        w_ready = '0;
        if (r_state == S_IDLE && w_found) begin
            w_ready[w_winner] = 1'b1;
        end
    end

    // Scheduler FSM; reset lands in WAIT so an in-flight frame can finish.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_WAIT;
            r_wait_cnt    <= c_cnt_max;
            r_rr_ptr      <= '0;
            r_grant_id    <= '0;
            r_tx_data     <= 8'h00;
            r_new_message <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_tx_data     <= req_data[{w_winner, 3'b000} +: 8];
                        r_grant_id    <= w_winner;
                        r_rr_ptr      <= w_next_ptr;
                        r_new_message <= 1'b1;
                        r_state       <= S_STROBE;
                    end
                end
                S_STROBE: begin
                    r_new_message <= 1'b0;
                    r_wait_cnt    <= c_cnt_max;
                    r_state       <= S_WAIT;
                end
                S_WAIT: begin
                    if (r_wait_cnt == '0) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_wait_cnt <= r_wait_cnt - c_cnt_w'(1);
                    end
                end
                default: begin
                    r_new_message <= 1'b0;
                    r_state       <= S_IDLE;
                end
            endcase
        end
    end

    assign req_ready   = w_ready;
    assign tx_data     = r_tx_data;
    assign new_message = r_new_message;
    assign grant_id    = r_grant_id;
    assign busy        = (r_state != S_IDLE);

`ifdef UART_TX_SCHED_STATS_EN
    logic [15:0] r_frame_count;

    // Count one frame per strobe cycle, wrapping naturally at 16 bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frame_count <= 16'h0000;
        end else if (r_state == S_STROBE) begin
            r_frame_count <= r_frame_count + 16'd1;
        end
    end

    assign frame_count = r_frame_count;
`else
    // Statistics counter not built in this configuration.
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_sched
// Purpose  : Self-checking bench for uart_tx_sched. Expected grants are
//            pushed to a scoreboard when stimulus is driven and popped when
//            the DUT accepts; timing, reset and hold-off windows are checked.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_sched;

    localparam int NUM_REQ = 2;
    localparam int GID_W   = 1;
    localparam int F       = 1155;
    localparam int SPACING = F + 2;

    typedef struct packed {
        logic [GID_W-1:0] id;
        logic [7:0]       data;
    } exp_t;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [NUM_REQ-1:0]   req_valid;
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   req_ready;
    logic [7:0]           tx_data;
    logic                 new_message;
    logic                 busy;
    logic [GID_W-1:0]     grant_id;
`ifdef UART_TX_SCHED_STATS_EN
    logic [15:0]          frame_count;
`endif

    uart_tx_sched #(
        .NUM_REQ   (NUM_REQ),
        .BIT_CYCLES(105),
        .FRAME_BITS(11),
        .GID_W     (GID_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .tx_data    (tx_data),
        .new_message(new_message),
        .busy       (busy),
        .grant_id   (grant_id)
`ifdef UART_TX_SCHED_STATS_EN
        ,
        .frame_count(frame_count)
`endif
    );

    always #5 clk = ~clk;

    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;
    int   last_acc = 0;
    int   m_frames = 0;
    logic [GID_W-1:0] m_rr = '0;
    exp_t sb[$];
    logic prev_nm = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Bus invariants: one-hot-or-zero accept, no back-to-back strobes.
    always @(negedge clk) begin
        #1;
        n_cmp++;
        if (!$onehot0(req_ready) || (new_message && prev_nm)) begin
            n_err++;
            $display("FAIL invariant: req_ready=%b new_message=%b prev_new_message=%b", req_ready, new_message, prev_nm);
        end
        prev_nm = new_message;
    end

    // Reference arbitration: first valid index scanning from the pointer.
    function automatic logic [GID_W-1:0] pick(input logic [NUM_REQ-1:0] v, input logic [GID_W-1:0] p);
        for (int k = 0; k < NUM_REQ; k++) begin
            int idx;
            idx = (int'(p) + k) % NUM_REQ;
            if (v[idx]) return GID_W'(idx);
        end
        return p;
    endfunction

    function automatic logic [GID_W-1:0] next_ptr(input logic [GID_W-1:0] w);
        return GID_W'((int'(w) + 1) % NUM_REQ);
    endfunction

    // Waits (bounded) until some req_ready bit is high.
    task automatic wait_accept(input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            #1;
            if (|req_ready) begin
                ok = 1'b1;
                return;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        bit   ok;
        int   rel;
        exp_t e;
        req_valid = 2'b01;
        req_data  = 16'h005A;
        rst_n     = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        n_cmp++; if (busy !== 1'b1)         begin n_err++; $display("FAIL reset_busy: got %b want 1", busy); end
        n_cmp++; if (req_ready !== 2'b00)   begin n_err++; $display("FAIL reset_ready: got %b want 00", req_ready); end
        n_cmp++; if (new_message !== 1'b0)  begin n_err++; $display("FAIL reset_nm: got %b want 0", new_message); end
        n_cmp++; if (tx_data !== 8'h00)     begin n_err++; $display("FAIL reset_tx: got %h want 00", tx_data); end
        n_cmp++; if (grant_id !== 1'b0)     begin n_err++; $display("FAIL reset_gid: got %h want 0", grant_id); end
        rst_n = 1'b1;
        rel = cyc;
        m_rr = '0;
        m_frames = 0;
        sb.push_back('{id: pick(req_valid, m_rr), data: 8'h5A});
        m_rr = next_ptr(pick(req_valid, m_rr));
        wait_accept(F + 10, ok);
        e = sb.pop_front();
        n_cmp++;
        if (!ok) begin n_err++; $display("FAIL reset_first_accept: got timeout want accept"); return; end
        if (cyc - rel !== F) begin n_err++; $display("FAIL reset_holdoff: got %0d cycles want %0d", cyc - rel, F); end
        n_cmp++; if (req_ready !== (2'b01 << e.id)) begin n_err++; $display("FAIL reset_ready_id: got %b want id %0d", req_ready, e.id); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_idle_busy: got %b want 0", busy); end
        last_acc = cyc;
        @(negedge clk); #1;
        n_cmp++; if (new_message !== 1'b1) begin n_err++; $display("FAIL reset_strobe: got %b want 1", new_message); end
        n_cmp++; if (tx_data !== e.data)   begin n_err++; $display("FAIL reset_tx_data: got %h want %h", tx_data, e.data); end
        n_cmp++; if (grant_id !== e.id)    begin n_err++; $display("FAIL reset_gid_after: got %h want %h", grant_id, e.id); end
        m_frames++;
    endtask

    task automatic test_single;
        bit   ok;
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            req_valid = 2'b10;
            req_data  = {8'(8'h10 + i), 8'hEE};
            sb.push_back('{id: pick(req_valid, m_rr), data: 8'(8'h10 + i)});
            m_rr = next_ptr(pick(req_valid, m_rr));
            wait_accept(SPACING + 10, ok);
            e = sb.pop_front();
            n_cmp++;
            if (!ok) begin n_err++; $display("FAIL single_accept: got timeout want accept %0d", i); return; end
            if (req_ready !== (2'b01 << e.id)) begin n_err++; $display("FAIL single_ready: got %b want id %0d", req_ready, e.id); end
            n_cmp++; if (cyc - last_acc !== SPACING) begin n_err++; $display("FAIL single_spacing: got %0d want %0d", cyc - last_acc, SPACING); end
            last_acc = cyc;
            @(negedge clk); #1;
            n_cmp++; if (new_message !== 1'b1) begin n_err++; $display("FAIL single_strobe: got %b want 1", new_message); end
            n_cmp++; if (tx_data !== e.data)   begin n_err++; $display("FAIL single_tx: got %h want %h", tx_data, e.data); end
            n_cmp++; if (grant_id !== e.id)    begin n_err++; $display("FAIL single_gid: got %h want %h", grant_id, e.id); end
            m_frames++;
        end
    endtask

    task automatic test_round_robin;
        bit   ok;
        exp_t e;
        req_valid = 2'b11;
        req_data  = {8'hB2, 8'hA1};
        for (int i = 0; i < 4; i++) begin
            e.id   = pick(req_valid, m_rr);
            e.data = (e.id == 1'b0) ? 8'hA1 : 8'hB2;
            sb.push_back(e);
            m_rr = next_ptr(e.id);
        end
        for (int i = 0; i < 4; i++) begin
            wait_accept(SPACING + 10, ok);
            e = sb.pop_front();
            n_cmp++;
            if (!ok) begin n_err++; $display("FAIL rr_accept: got timeout want accept %0d", i); return; end
            if (req_ready !== (2'b01 << e.id)) begin n_err++; $display("FAIL rr_ready: got %b want id %0d", req_ready, e.id); end
            n_cmp++; if (cyc - last_acc !== SPACING) begin n_err++; $display("FAIL rr_spacing: got %0d want %0d", cyc - last_acc, SPACING); end
            last_acc = cyc;
            @(negedge clk); #1;
            n_cmp++; if (new_message !== 1'b1) begin n_err++; $display("FAIL rr_strobe: got %b want 1", new_message); end
            n_cmp++; if (tx_data !== e.data)   begin n_err++; $display("FAIL rr_tx: got %h want %h", tx_data, e.data); end
            n_cmp++; if (grant_id !== e.id)    begin n_err++; $display("FAIL rr_gid: got %h want %h", grant_id, e.id); end
            m_frames++;
        end
        req_valid = 2'b00;
    endtask

    task automatic test_wait_window;
        int a;
        a = last_acc;
        while (cyc < a + 500) begin @(negedge clk); #1; end
        req_valid = 2'b01;
        req_data  = 16'h0077;
        for (int i = 0; i < 50; i++) begin
            #1;
            n_cmp++;
            if (req_ready !== 2'b00 || new_message !== 1'b0 || busy !== 1'b1) begin
                n_err++;
                $display("FAIL wait_window: got ready=%b nm=%b busy=%b want 00/0/1", req_ready, new_message, busy);
            end
            @(negedge clk);
        end
        req_valid = 2'b00;
        #1;
        while (cyc < a + SPACING - 1) begin
            @(negedge clk); #1;
            n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL wait_busy: got %b want 1 at +%0d", busy, cyc - a); end
        end
        @(negedge clk); #1;
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL wait_expiry: got busy %b want 0 at +%0d", busy, cyc - a); end
        repeat (5) @(negedge clk);
        #1;
        n_cmp++;
        if (new_message !== 1'b0 || tx_data !== 8'hB2 || req_ready !== 2'b00) begin
            n_err++;
            $display("FAIL wait_no_capture: got nm=%b tx=%h ready=%b want 0/B2/00", new_message, tx_data, req_ready);
        end
    endtask

    task automatic test_midreset;
        bit   ok;
        int   rel;
        exp_t e;
        req_valid = 2'b11;
        req_data  = {8'hC4, 8'hC3};
        e.id   = pick(req_valid, m_rr);
        e.data = (e.id == 1'b0) ? 8'hC3 : 8'hC4;
        sb.push_back(e);
        m_rr = next_ptr(e.id);
        wait_accept(10, ok);
        e = sb.pop_front();
        n_cmp++;
        if (!ok) begin n_err++; $display("FAIL midrst_accept: got timeout want accept"); return; end
        if (req_ready !== (2'b01 << e.id)) begin n_err++; $display("FAIL midrst_ready: got %b want id %0d", req_ready, e.id); end
        @(negedge clk); #1;
        n_cmp++; if (new_message !== 1'b1 || tx_data !== e.data) begin n_err++; $display("FAIL midrst_strobe: got nm=%b tx=%h want 1/%h", new_message, tx_data, e.data); end
        repeat (3) @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (busy !== 1'b1 || new_message !== 1'b0 || tx_data !== 8'h00 || grant_id !== 1'b0 || req_ready !== 2'b00) begin
            n_err++;
            $display("FAIL midrst_values: got busy=%b nm=%b tx=%h gid=%h ready=%b want 1/0/00/0/00", busy, new_message, tx_data, grant_id, req_ready);
        end
        repeat (2) @(negedge clk);
        #1;
        rst_n = 1'b1;
        rel = cyc;
        m_rr = '0;
        m_frames = 0;
        e.id   = pick(req_valid, m_rr);
        e.data = (e.id == 1'b0) ? 8'hC3 : 8'hC4;
        sb.push_back(e);
        m_rr = next_ptr(e.id);
        wait_accept(F + 10, ok);
        e = sb.pop_front();
        n_cmp++;
        if (!ok) begin n_err++; $display("FAIL midrst_post_accept: got timeout want accept"); return; end
        if (cyc - rel !== F) begin n_err++; $display("FAIL midrst_holdoff: got %0d cycles want %0d", cyc - rel, F); end
        n_cmp++; if (req_ready !== (2'b01 << e.id)) begin n_err++; $display("FAIL midrst_rr_reset: got %b want id %0d", req_ready, e.id); end
        last_acc = cyc;
        @(negedge clk); #1;
        n_cmp++; if (new_message !== 1'b1 || tx_data !== e.data || grant_id !== e.id) begin n_err++; $display("FAIL midrst_post_strobe: got nm=%b tx=%h gid=%h want 1/%h/%h", new_message, tx_data, grant_id, e.data, e.id); end
        m_frames++;
        req_valid = 2'b00;
    endtask

`ifdef UART_TX_SCHED_STATS_EN
    task automatic test_stats;
        bit   ok;
        exp_t e;
        for (int i = 0; i < 5; i++) begin
            if (i == 4) begin
                n_cmp++; if (frame_count !== 16'(m_frames)) begin n_err++; $display("FAIL stats_count: got %0d want %0d", frame_count, m_frames); end
                force dut.r_frame_count = 16'hFFFF;
                @(negedge clk); #1;
                release dut.r_frame_count;
            end
            req_valid = 2'b01;
            req_data  = {8'h00, 8'(8'h30 + i)};
            e.id   = pick(req_valid, m_rr);
            e.data = 8'(8'h30 + i);
            sb.push_back(e);
            m_rr = next_ptr(e.id);
            wait_accept(SPACING + 10, ok);
            e = sb.pop_front();
            n_cmp++;
            if (!ok) begin n_err++; $display("FAIL stats_accept: got timeout want accept %0d", i); return; end
            if (req_ready !== (2'b01 << e.id)) begin n_err++; $display("FAIL stats_ready: got %b want id %0d", req_ready, e.id); end
            @(negedge clk); #1;
            req_valid = 2'b00;
            m_frames++;
            @(negedge clk); #1;
        end
        n_cmp++; if (frame_count !== 16'h0000) begin n_err++; $display("FAIL stats_wrap: got %h want 0000", frame_count); end
    endtask
`endif

    initial begin
        rst_n     = 1'b0;
        req_valid = '0;
        req_data  = '0;
        test_reset;
        test_single;
        test_round_robin;
        test_wait_window;
        test_midreset;
`ifdef UART_TX_SCHED_STATS_EN
        test_stats;
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_tx_sched.md
Name: uart_tx_sched

Overview:
- Round-robin scheduler that shares the single 8N1 UART transmitter between NUM_REQ byte producers, e.g. CPU output port and debug dump.
- Accepts one byte per grant over a valid/ready handshake and presents it on tx_data.
- Fires the transmitter's new_message strobe, then holds off all requesters for one full frame time, because the transmitter has no busy output.
- Sits between the producers and the UART TX; tx_data and new_message connect directly to the transmitter's data and strobe inputs.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- BIT_CYCLES, 105, clk cycles per UART bit; matches the transmitter's baud divider (0..104).
- FRAME_BITS, 11, bit periods reserved per frame: start + 8 data + stop + 1 guard; must be >= 10.
- GID_W, 1, grant_id width; equals ceil(log2(NUM_REQ)), minimum 1.

Ports:
- clk, in, 1, system clock.
- rst_n, in, 1, asynchronous active-low reset.
- req_valid, in, NUM_REQ, bit i: requester i holds a byte; it must stay high with data stable until accepted.
- req_data, in, 8*NUM_REQ, byte of requester i on bits [8i+7:8i].
- req_ready, out, NUM_REQ, one-hot accept; combinational from state/valid/pointer; high for one cycle only.
- tx_data, out, 8, byte to transmitter; stable from STROBE until next accept.
- new_message, out, 1, one-cycle-high transmit strobe.
- busy, out, 1, high whenever state != IDLE.
- grant_id, out, GID_W, index of last accepted requester.

Behaviour:
- Let F = FRAME_BITS*BIT_CYCLES (default 1155). wait_cnt is a down-counter wide enough for F-1.
- Reset values (async, rst_n low):
  - state=WAIT, wait_cnt=F-1, rr_ptr=0.
  - tx_data=0, new_message=0, grant_id=0, busy=1, req_ready=0.
  - Reset starts in WAIT so a frame the unreset transmitter may still be shifting completes before the first grant.
- IDLE:
  - If any req_valid is set, winner w = first set bit scanning rr_ptr, rr_ptr+1, ... mod NUM_REQ.
  - req_ready[w]=1 in the same cycle.
  - On that edge: tx_data<=req_data[w], grant_id<=w, rr_ptr<=(w+1) mod NUM_REQ, state<=STROBE.
  - With no valid: stay in IDLE, outputs unchanged.
- STROBE:
  - new_message=1 for exactly this cycle; req_ready=0.
  - Next: wait_cnt<=F-1, state<=WAIT.
- WAIT:
  - new_message=0, req_ready=0; wait_cnt decrements each cycle.
  - When wait_cnt==0: state<=IDLE.
- Timing:
  - Accept at cycle A; new_message high in cycle A+1; WAIT spans A+2..A+1+F.
  - Next accept is possible at A+2+F (default 1157 cycles between accepts).
- Boundaries:
  - req_valid rising during STROBE/WAIT: ignored until IDLE; no data captured.
  - req_valid dropped in IDLE before accept: no transfer, rr_ptr unchanged.
  - Only one requester valid: it wins regardless of rr_ptr.
  - rr_ptr wraps from NUM_REQ-1 to 0.
  - rst_n asserted mid-WAIT or mid-STROBE: immediate return to reset values; the pending byte is dropped; after release, a full F-cycle WAIT precedes any grant.
  - Never more than one req_ready bit high; never new_message high in two consecutive cycles.

Optional Feature:
- Macro UART_TX_SCHED_STATS_EN.
- Defined:
  - Adds output frame_count (16 bits), reset 0.
  - Increments by 1 (wrapping 0xFFFF->0) on each STROBE cycle.
- Undefined:
  - Port and counter absent; all other behaviour identical.

Test Plan:
- Reset release with req_valid=2'b01 held -> busy=1 and no req_ready for 1155 cycles; req_ready[0] in cycle 1155 after release; new_message pulse next cycle with tx_data=req_data[7:0].
- Both valid continuously, req_data={8'hB2,8'hA1}:
  - accepts alternate 0,1,0,1 with grant_id matching;
  - tx_data sequence A1,B2,A1,B2;
  - accept-to-accept spacing exactly 1157 cycles.
- Only requester 1 valid for 3 bytes (0x10,0x11,0x12) -> three accepts of requester 1, each 1157 cycles apart; tx_data follows.
- req_valid[0] pulsed high only during a WAIT window -> no req_ready, no new_message, busy stays high until counter expiry.
- Assert rst_n low 3 cycles after a new_message pulse -> outputs reset immediately; after release, 1155 cycles before the next req_ready despite valid held high.
- With UART_TX_SCHED_STATS_EN: 5 transfers -> frame_count=5. Preload near wrap (force 16'hFFFF) and send one more -> 0.
